// File: rtl/sram_1rw1r_param_if.sv
// rtl/sram_1rw1r_param_if.sv - request/response bundle for the 1RW+1R SRAM model
interface sram_1rw1r_param_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WMASK_WIDTH = 8
);
    localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;

    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  rvalid0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  rvalid1;
    logic                  busy;
    logic                  collision;
    logic [15:0]           collision_count;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1,
        input  dout0, rvalid0, dout1, rvalid1, busy, collision, collision_count
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output dout0, rvalid0, dout1, rvalid1, busy, collision, collision_count
    );
endinterface

// File: rtl/sram_1rw1r_param.sv
// rtl/sram_1rw1r_param.sv - parametrised 1RW+1R synchronous SRAM with clear sequencer
module sram_1rw1r_param #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    WMASK_WIDTH    = 8,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    BYPASS         = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input logic               clk,
    input logic               reset,
    sram_1rw1r_param_if.slave bus
);
    localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram_1rw1r_param: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_lanes
        $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  ready, clr_en, wr_en, rd0_en, rd1_en, collide;
    logic [DATA_WIDTH-1:0] rd0_data, rd1_data;

    logic                  s1_v0, s1_v1, s1_col;
    logic [DATA_WIDTH-1:0] s1_d0, s1_d1;
    logic                  f_v0, f_v1, f_col;
    logic [DATA_WIDTH-1:0] f_d0, f_d1;

    assign ready   = (state == S_READY) && !reset;
    assign clr_en  = (state == S_CLEAR) && !reset;
    assign wr_en   = ready && !bus.csb0 && !bus.web0;
    assign rd0_en  = ready && !bus.csb0 && bus.web0;
    assign rd1_en  = ready && !bus.csb1;
    assign collide = wr_en && rd1_en && (|bus.wmask0) && (bus.addr0 == bus.addr1);

    // Port 1 sees the merged word only when bypassing a same-edge write.
    always_comb begin
        rd0_data = mem[bus.addr0];
        rd1_data = mem[bus.addr1];
        if (BYPASS != 0 && collide) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (bus.wmask0[i]) begin
                    rd1_data[i*WMASK_WIDTH +: WMASK_WIDTH] = bus.din0[i*WMASK_WIDTH +: WMASK_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            clr_addr <= '0;
            bus.busy <= (CLEAR_ON_RESET != 0);
        end else if (state == S_CLEAR) begin
            clr_addr <= clr_addr + ADDR_WIDTH'(1);
            if (clr_addr == '1) begin
                state    <= S_READY;
                bus.busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= CLEAR_VALUE;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (bus.wmask0[i]) begin
                    mem[bus.addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= bus.din0[i*WMASK_WIDTH +: WMASK_WIDTH];
                end
            end
        end
    end

    // Latency 1 retires the live request; latency 2 retires the stage-1 copy.
    always_comb begin
        if (READ_LATENCY == 1) begin
            f_v0  = rd0_en;
            f_d0  = rd0_data;
            f_v1  = rd1_en;
            f_d1  = rd1_data;
            f_col = collide;
        end else begin
            f_v0  = s1_v0;
            f_d0  = s1_d0;
            f_v1  = s1_v1;
            f_d1  = s1_d1;
            f_col = s1_col;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v0               <= 1'b0;
            s1_v1               <= 1'b0;
            s1_col              <= 1'b0;
            s1_d0               <= '0;
            s1_d1               <= '0;
            bus.dout0           <= '0;
            bus.dout1           <= '0;
            bus.rvalid0         <= 1'b0;
            bus.rvalid1         <= 1'b0;
            bus.collision       <= 1'b0;
            bus.collision_count <= '0;
        end else begin
            s1_v0         <= rd0_en;
            s1_v1         <= rd1_en;
            s1_col        <= collide;
            s1_d0         <= rd0_data;
            s1_d1         <= rd1_data;
            bus.rvalid0   <= f_v0;
            bus.rvalid1   <= f_v1;
            bus.collision <= f_col;
            if (f_v0) begin
                bus.dout0 <= f_d0;
            end
            if (f_v1) begin
                bus.dout1 <= f_d1;
            end
            if (f_col && bus.collision_count != 16'hFFFF) begin
                bus.collision_count <= bus.collision_count + 16'd1;
            end
        end
    end
endmodule
